// File: rtl/egk_bin_pkg.sv
// Shared types and helpers for the EGk bin serializer.
//   ser_state_t      : serializer FSM state encoding
//   cnt_width()      : width of a bin counter that can hold 0..bin_width
//   BIN_WIDTH_DEF    : default codeword / shift register width
//   LEN_WIDTH_DEF    : default width of the binarizer length field
package egk_bin_pkg;

   localparam int BIN_WIDTH_DEF = 16;
   localparam int LEN_WIDTH_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   function automatic int cnt_width(input int bin_width);
      return $clog2(bin_width + 1);
   endfunction

endpackage

// File: rtl/egk_bin_serializer.sv
// EGk bin serializer: accepts one codeword (code value + bin count) per
// transfer and emits it one bin per cycle, MSB-first, over valid/ready.
// A new codeword can be accepted in the cycle the previous one's last bin
// is taken, so back-to-back words stream with no bubble.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid_i      codeword present on code_i/len_i
//   in_ready_o      can accept a codeword this cycle (combinational from
//                   bin_ready_i while the last bin is being presented)
//   code_i, len_i   codeword; bins are code_i[len-1] .. code_i[0]
//   bin_o           current bin
//   bin_valid_o     bin_o is valid
//   bin_ready_i     downstream takes bin_o this cycle
//   last_o          current bin ends its codeword
//   len_err_o       sticky: some len_i exceeded BIN_WIDTH (clamped)
//   bin_count_o     32-bit wrapping count of output transfers
//                   (only when EGK_BIN_COUNT_EN is defined)
//
// State table:
//   IDLE  | no codeword held; ready for input, no bin output
//   SHIFT | presenting shreg_q[cnt_q-1]; cnt_q bins remain
module egk_bin_serializer
   import egk_bin_pkg::*;
#(
   parameter int BIN_WIDTH = BIN_WIDTH_DEF,
   parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [BIN_WIDTH-1:0] code_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   output logic                 bin_o,
   output logic                 bin_valid_o,
   input  logic                 bin_ready_i,
   output logic                 last_o,
   output logic                 len_err_o
`ifdef EGK_BIN_COUNT_EN
   ,
   output logic [31:0]          bin_count_o
`endif
);

   localparam int CW = cnt_width(BIN_WIDTH);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(BIN_WIDTH);
   localparam logic [CW-1:0]        CNT_MAX  = CW'(BIN_WIDTH);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic [BIN_WIDTH-1:0] BIT0     = BIN_WIDTH'(1);

   ser_state_t           state_q, state_d;
   logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 len_err_q, len_err_d;

   logic                 len_over;
   logic                 len_zero;
   logic [CW-1:0]        load_cnt;
   logic                 cur_bin;
   logic                 is_last;

   assign len_over = (len_i > LEN_MAX);
   assign len_zero = (len_i == '0);
   assign load_cnt = len_over ? CNT_MAX : CW'(len_i);
   assign is_last  = (cnt_q == CNT_ONE);

   // Mask-and-reduce rather than a variable bit-select so the index never
   // needs to fit the shreg range (cnt_q-1 wraps when cnt_q is 0 in IDLE).
   assign cur_bin  = |(shreg_q & (BIT0 << (cnt_q - CNT_ONE)));

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      in_ready_o  = 1'b0;
      bin_valid_o = 1'b0;
      bin_o       = 1'b0;
      last_o      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i && !len_zero) begin
               shreg_d = code_i;
               cnt_d   = load_cnt;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bin_valid_o = 1'b1;
            bin_o       = cur_bin;
            last_o      = is_last;
            in_ready_o  = is_last && bin_ready_i;
            if (bin_ready_i) begin
               if (!is_last) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else if (in_valid_i && !len_zero) begin
                  shreg_d = code_i;
                  cnt_d   = load_cnt;
               end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      len_err_d = len_err_q | (in_valid_i && in_ready_o && len_over);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign len_err_o = len_err_q;

`ifdef EGK_BIN_COUNT_EN
   logic [31:0] bin_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_count_q <= '0;
      end else if (bin_valid_o && bin_ready_i) begin
         bin_count_q <= bin_count_q + 32'd1;
      end
   end

   assign bin_count_o = bin_count_q;
`endif

endmodule

// File: tb/tb_egk_bin_serializer.sv
module tb_egk_bin_serializer;

   localparam int BW = 16;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] code;
   logic [15:0] len;
   logic        bin;
   logic        bin_valid;
   logic        bin_ready;
   logic        last;
   logic        len_err;
`ifdef EGK_BIN_COUNT_EN
   logic [31:0] bin_count;
`endif

   int npass  = 0;
   int ntotal = 0;

   egk_bin_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .code_i      (code),
      .len_i       (len),
      .bin_o       (bin),
      .bin_valid_o (bin_valid),
      .bin_ready_i (bin_ready),
      .last_o      (last),
      .len_err_o   (len_err)
`ifdef EGK_BIN_COUNT_EN
      ,
      .bin_count_o (bin_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; code = '0; len = '0; bin_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #3;
      ntotal++;
      if ({bin_valid, bin, last, len_err, in_ready} !== 5'b00001)
         $display("FAIL reset_outputs got %b want 00001", {bin_valid, bin, last, len_err, in_ready});
      else npass++;
`ifdef EGK_BIN_COUNT_EN
      ntotal++;
      if (bin_count !== 32'd0) $display("FAIL reset_count got %0d want 0", bin_count);
      else npass++;
`endif
      tick();
   endtask

   task automatic test_single();
      logic [4:0] exp_bins;
      exp_bins = 5'b00101;
      in_valid = 1'b1; code = 16'h0005; len = 16'd5; bin_ready = 1'b1;
      #3;
      ntotal++;
      if (in_ready !== 1'b1) $display("FAIL single_accept in_ready got %b want 1", in_ready);
      else npass++;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #3;
         ntotal++;
         if ({bin_valid, bin, last} !== {1'b1, exp_bins[5-c], (c == 5)})
            $display("FAIL single_bin%0d got v/b/l %b want %b", c, {bin_valid, bin, last},
                     {1'b1, exp_bins[5-c], (c == 5)});
         else npass++;
         if (c == 5) begin
            ntotal++;
            if (in_ready !== 1'b1) $display("FAIL single_ready_last got %b want 1", in_ready);
            else npass++;
         end
         tick();
      end
      #3;
      ntotal++;
      if ({bin_valid, in_ready} !== 2'b01) $display("FAIL single_idle got %b want 01", {bin_valid, in_ready});
      else npass++;
      tick();
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; code = 16'h0003; len = 16'd2; bin_ready = 1'b1;
      tick();
      code = 16'h0001; len = 16'd1;
      #3;
      ntotal++;
      if ({bin_valid, bin, last, in_ready} !== 4'b1100)
         $display("FAIL b2b_bin1 got v/b/l/r %b want 1100", {bin_valid, bin, last, in_ready});
      else npass++;
      tick();
      #3;
      ntotal++;
      if ({bin_valid, bin, last, in_ready} !== 4'b1111)
         $display("FAIL b2b_bin2 got v/b/l/r %b want 1111", {bin_valid, bin, last, in_ready});
      else npass++;
      tick();
      in_valid = 1'b0;
      #3;
      ntotal++;
      if ({bin_valid, bin, last} !== 3'b111)
         $display("FAIL b2b_bin3 got v/b/l %b want 111", {bin_valid, bin, last});
      else npass++;
      tick();
      #3;
      ntotal++;
      if (bin_valid !== 1'b0) $display("FAIL b2b_end bin_valid got %b want 0", bin_valid);
      else npass++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [2:0] exp_bins;
      int         xfers;
      exp_bins = 3'b101;
      xfers = 0;
      in_valid = 1'b1; code = 16'h0005; len = 16'd3; bin_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #3;
         ntotal++;
         if ({bin_valid, bin, last} !== 3'b110)
            $display("FAIL bp_hold%0d got v/b/l %b want 110", c, {bin_valid, bin, last});
         else npass++;
         tick();
      end
      bin_ready = 1'b1;
      for (int c = 0; c < 10 && bin_valid; c++) begin
         #3;
         if (bin_valid && bin_ready) begin
            ntotal++;
            if (xfers > 2 || {bin, last} !== {exp_bins[2-xfers], (xfers == 2)})
               $display("FAIL bp_bin%0d got b/l %b want %b", xfers, {bin, last},
                        {exp_bins[2-(xfers%3)], (xfers == 2)});
            else npass++;
            xfers++;
         end
         tick();
      end
      ntotal++;
      if (xfers != 3) $display("FAIL bp_xfers got %0d want 3", xfers);
      else npass++;
   endtask

   task automatic test_zero_len();
      in_valid = 1'b1; code = 16'hFFFF; len = 16'd0; bin_ready = 1'b1;
      #3;
      ntotal++;
      if (in_ready !== 1'b1) $display("FAIL zero_accept got %b want 1", in_ready);
      else npass++;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #3;
         ntotal++;
         if ({bin_valid, in_ready} !== 2'b01)
            $display("FAIL zero_idle%0d got v/r %b want 01", c, {bin_valid, in_ready});
         else npass++;
         tick();
      end
   endtask

   task automatic test_overlong();
      int xfers;
      xfers = 0;
      in_valid = 1'b1; code = 16'hFFFF; len = 16'd20; bin_ready = 1'b1;
      #3;
      ntotal++;
      if (len_err !== 1'b0) $display("FAIL overlong_err_before got %b want 0", len_err);
      else npass++;
      tick();
      in_valid = 1'b0;
      #3;
      ntotal++;
      if (len_err !== 1'b1) $display("FAIL overlong_err_next got %b want 1", len_err);
      else npass++;
      for (int c = 0; c < 40 && bin_valid; c++) begin
         ntotal++;
         if ({bin, last} !== {1'b1, (xfers == 15)})
            $display("FAIL overlong_bin%0d got b/l %b want %b", xfers, {bin, last}, {1'b1, (xfers == 15)});
         else npass++;
         xfers++;
         tick();
         #3;
      end
      ntotal++;
      if (xfers != 16) $display("FAIL overlong_xfers got %0d want 16", xfers);
      else npass++;
      tick(); tick();
      #3;
      ntotal++;
      if (len_err !== 1'b1) $display("FAIL overlong_sticky got %b want 1", len_err);
      else npass++;
      tick();
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; code = 16'h001F; len = 16'd5; bin_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #3;
      ntotal++;
      if ({bin_valid, bin, last, in_ready, len_err} !== 5'b00010)
         $display("FAIL rstmid got v/b/l/r/e %b want 00010", {bin_valid, bin, last, in_ready, len_err});
      else npass++;
`ifdef EGK_BIN_COUNT_EN
      ntotal++;
      if (bin_count !== 32'd0) $display("FAIL rstmid_count got %0d want 0", bin_count);
      else npass++;
`endif
      tick();
   endtask

   task automatic test_random();
      logic [1:0]  q[$];
      logic [1:0]  ent;
      logic        exp_err;
      logic        exp_ready;
      logic        took;
      int          n;
      int unsigned exp_cnt;
      exp_err = 1'b0;
      exp_cnt = 0;
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      took = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (took || !in_valid) begin
            in_valid = ($urandom_range(0, 2) != 0);
            code     = 16'($urandom);
            len      = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(17, 40))
                                                   : 16'($urandom_range(0, 16));
         end
         bin_ready = ($urandom_range(0, 3) != 0);
         #3;
         exp_ready = (q.size() == 0) || (q.size() == 1 && bin_ready);
         ntotal++;
         if ({bin_valid, in_ready, len_err} !== {(q.size() != 0), exp_ready, exp_err})
            $display("FAIL rand_ctrl cyc%0d got v/r/e %b want %b", cyc, {bin_valid, in_ready, len_err},
                     {(q.size() != 0), exp_ready, exp_err});
         else npass++;
`ifdef EGK_BIN_COUNT_EN
         ntotal++;
         if (bin_count !== exp_cnt) $display("FAIL rand_count cyc%0d got %0d want %0d", cyc, bin_count, exp_cnt);
         else npass++;
`endif
         if (q.size() != 0 && bin_ready) begin
            ent = q.pop_front();
            exp_cnt++;
            ntotal++;
            if ({bin, last} !== ent)
               $display("FAIL rand_bin cyc%0d got b/l %b want %b", cyc, {bin, last}, ent);
            else npass++;
         end
         took = in_valid && exp_ready;
         if (took) begin
            n = (len > 16'd16) ? 16 : int'(len);
            if (len > 16'd16) exp_err = 1'b1;
            for (int i = n - 1; i >= 0; i--) q.push_back({code[i], (i == 0)});
         end
         tick();
      end
      in_valid = 1'b0;
      bin_ready = 1'b1;
      for (int c = 0; c < 40 && q.size() != 0; c++) begin
         #3;
         ent = q.pop_front();
         ntotal++;
         if ({bin_valid, bin, last} !== {1'b1, ent})
            $display("FAIL rand_drain got v/b/l %b want %b", {bin_valid, bin, last}, {1'b1, ent});
         else npass++;
         tick();
      end
      #3;
      ntotal++;
      if ({bin_valid, in_ready} !== 2'b01 || q.size() != 0)
         $display("FAIL rand_end got v/r %b want 01 (left %0d)", {bin_valid, in_ready}, q.size());
      else npass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_zero_len();
      test_overlong();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
